sent_config_bank: RTL and testbench
===================================

Name: sent_config_bank

Overview:
- Parametrised successor to the single-shot SENT parameter parser.
- Parses SENT parameter frames from the user UDP receive stream into a CH_NUM-deep per-channel register bank.
- Validates frame length, channel index and field ranges; supports broadcast.
- Hands each updated config to its SENT channel via a per-channel valid/ready handshake, with overrun and error accounting.

Parameters:
ID_SENT_PARAM, 2, frame ID expected in word0 bits[23:16].
CH_NUM, 8, number of SENT channels (1..32).
BCAST_IDX, 8'hFF, channel index meaning "all channels".
CNT_W, 16, width of the saturating statistics counters.

Ports:
clk  in  1  block clock
rst_n  in  1  reset, asynchronous assert, active-low; all state cleared
rx_axis_udp_tdata  in  32  UDP payload word
rx_axis_udp_tvalid  in  1  beat valid (no backpressure)
rx_axis_udp_tlast  in  1  last beat of frame
cfg_vld  out  CH_NUM  per-channel config pending
cfg_rdy  in  CH_NUM  channel accepts config
sent_ctick_len  out  CH_NUM*8  tick length (us), channel i at [8i+7:8i]
sent_ltick_len  out  CH_NUM*8  low-pulse ticks
sent_pause_mode  out  CH_NUM*2  pause mode
sent_pause_len  out  CH_NUM*16  pause length (ticks)
sent_crc_mode  out  CH_NUM  CRC mode
sent_status_nibble  out  CH_NUM*4  status/comm nibble
sent_data_len  out  CH_NUM*3  data nibbles
sent_data_nibble  out  CH_NUM*24  data {n1..n6}
err_flags  out  4  sticky {overrun, range, chan, len}
err_clr  in  1  pulse; clears err_flags
cfg_ok_cnt  out  CNT_W  committed frames, saturating
cfg_err_cnt  out  CNT_W  rejected frames, saturating

Behaviour:
- Reset: every output, bank entry, counter, flag and the FSM go to 0/IDLE immediately on rst_n low. A frame in flight at reset is lost; parsing restarts with the next frame's first beat after release.
- Input: one register stage (tdata/tvalid/tlast). The FSM acts only on registered beats with tvalid=1; gaps between beats are allowed.
- Frame layout (word0..word3):
  - word0: [31:16] frame ID check uses [23:16]; [15:8] channel.
  - word1: [31:24] ctick; [23:16] ltick; [9:8] pause mode; [7:0] pause_len[15:8].
  - word2: [31:24] pause_len[7:0]; [16] crc mode; [11:8] status nibble; [2:0] data_len.
  - word3: [31:8] data.
- FSM states: IDLE, W1, W2, W3, EXTRA, DROP.
  - IDLE, beat: if [23:16]==ID_SENT_PARAM, latch channel into staging and go to W1; else go to DROP. A single-beat frame (tlast) stays in IDLE. A foreign-ID frame is silent: no error, no count.
  - W1/W2: latch fields into staging. tlast here raises a len error and returns to IDLE.
  - W3: latch data. With tlast, capture the commit record and go to IDLE. Without tlast, go to EXTRA.
  - EXTRA: discard beats until tlast, then raise a len error and go to IDLE.
  - DROP: discard beats until tlast, then go to IDLE.
- Validation runs on the commit record, with this priority: chan > range > len.
  - chan error: channel >= CH_NUM and channel != BCAST_IDX.
  - range error: any of ctick<3, ctick>90, ltick<4, pause_mode==3, data_len==0, data_len>6, or (pause_mode!=0 and (pause_len<12 or pause_len>768)).
  - Each error sets its sticky err_flags bit and increments cfg_err_cnt once per frame. The bank is untouched.
- Commit: applied the cycle after the record is captured. The FSM keeps accepting the next frame's word0 meanwhile; the commit record is independent of staging.
  - Target channel, or all channels for broadcast: bank entry written and cfg_vld[i] set. cfg_ok_cnt increments by 1 per frame, including broadcast frames.
  - Latency: tlast beat sampled at edge E0; cfg_vld and bank outputs change after edge E2.
- Handshake:
  - cfg_vld[i] clears on the edge where cfg_vld[i]&cfg_rdy[i].
  - Bank outputs for channel i are stable while cfg_vld[i]=1 unless overwritten.
  - Commit to a channel whose cfg_vld is already 1: new values overwrite (latest wins), cfg_vld stays 1, overrun flag set.
  - Commit and ready in the same cycle on the same channel: the commit wins and cfg_vld stays 1. Overrun is not flagged, because the old config was consumed.
- Counters saturate at all-ones.
- err_clr coincident with a new error: the error wins and the flag stays set.

Test Plan:
- Valid frame, channel 3: ctick=5, ltick=4, pause_mode=1, pause_len=20, crc=1, status=0xA, data_len=6, data=0x123456 -> after E2, cfg_vld=8'b00001000 and channel-3 fields match. cfg_rdy[3] one cycle later -> cfg_vld=0; cfg_ok_cnt=1.
- Broadcast (channel 0xFF) with CH_NUM=8 -> all 8 entries equal, cfg_vld=8'hFF; cfg_ok_cnt increments by exactly 1.
- Faults: ctick=91; data_len=0; channel 9; 3-word frame; 5-word frame -> bank unchanged, cfg_vld=0, err_flags={0,1,1,1}, cfg_err_cnt=5. err_clr -> err_flags=0.
- Two back-to-back valid frames to channel 2 (no gap beats), cfg_rdy low -> bank holds the second frame, err_flags[3]=1, cfg_ok_cnt=2.
- Foreign frame ID=1, 4 words, followed immediately by a valid frame -> first ignored with counters unchanged; second commits normally.
- rst_n asserted mid-frame (after word1) -> outputs 0 immediately; after release a complete valid frame commits with correct latency.

Source files
------------

// File: rtl/sent_config_bank_if.sv
// Bus bundle for sent_config_bank: UDP receive stream, per-channel config handshake,
// flattened bank outputs and error/statistics reporting.
interface sent_config_bank_if #(
    parameter int CH_NUM = 8,
    parameter int CNT_W  = 16
);
    logic [31:0]          rx_axis_udp_tdata;
    logic                 rx_axis_udp_tvalid;
    logic                 rx_axis_udp_tlast;
    logic [CH_NUM-1:0]    cfg_vld;
    logic [CH_NUM-1:0]    cfg_rdy;
    logic [CH_NUM*8-1:0]  sent_ctick_len;
    logic [CH_NUM*8-1:0]  sent_ltick_len;
    logic [CH_NUM*2-1:0]  sent_pause_mode;
    logic [CH_NUM*16-1:0] sent_pause_len;
    logic [CH_NUM-1:0]    sent_crc_mode;
    logic [CH_NUM*4-1:0]  sent_status_nibble;
    logic [CH_NUM*3-1:0]  sent_data_len;
    logic [CH_NUM*24-1:0] sent_data_nibble;
    logic [3:0]           err_flags;
    logic                 err_clr;
    logic [CNT_W-1:0]     cfg_ok_cnt;
    logic [CNT_W-1:0]     cfg_err_cnt;

    modport slave (
        input  rx_axis_udp_tdata, rx_axis_udp_tvalid, rx_axis_udp_tlast, cfg_rdy, err_clr,
        output cfg_vld, sent_ctick_len, sent_ltick_len, sent_pause_mode, sent_pause_len,
               sent_crc_mode, sent_status_nibble, sent_data_len, sent_data_nibble,
               err_flags, cfg_ok_cnt, cfg_err_cnt
    );

    modport master (
        output rx_axis_udp_tdata, rx_axis_udp_tvalid, rx_axis_udp_tlast, cfg_rdy, err_clr,
        input  cfg_vld, sent_ctick_len, sent_ltick_len, sent_pause_mode, sent_pause_len,
               sent_crc_mode, sent_status_nibble, sent_data_len, sent_data_nibble,
               err_flags, cfg_ok_cnt, cfg_err_cnt
    );
endinterface

// File: rtl/sent_config_bank.sv
// SENT parameter frame parser feeding a per-channel config bank with valid/ready
// hand-off, broadcast support, sticky error flags and saturating statistics.
module sent_config_bank #(
    parameter int         ID_SENT_PARAM = 2,
    parameter int         CH_NUM        = 8,
    parameter logic [7:0] BCAST_IDX     = 8'hFF,
    parameter int         CNT_W         = 16
) (
    input logic               clk,
    input logic               rst_n,
    sent_config_bank_if.slave bus
);
    typedef struct packed {
        logic [7:0]  ctick;
        logic [7:0]  ltick;
        logic [1:0]  pmode;
        logic [15:0] plen;
        logic        crc;
        logic [3:0]  status;
        logic [2:0]  dlen;
        logic [23:0] data;
    } cfg_t;

    typedef enum logic [2:0] {IDLE, W1, W2, W3, EXTRA, DROP} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic out_of_range(input cfg_t c);
        logic bad;
        bad = (c.ctick < 8'd3) || (c.ctick > 8'd90) || (c.ltick < 8'd4) ||
              (c.pmode == 2'd3) || (c.dlen == 3'd0) || (c.dlen > 3'd6);
        if ((c.pmode != 2'd0) && ((c.plen < 16'd12) || (c.plen > 16'd768))) bad = 1'b1;
        return bad;
    endfunction

    logic [31:0] in_data_q;
    logic        in_vld_q;
    logic        in_last_q;

    state_t      state_q;
    cfg_t        stage_q;
    logic [7:0]  stage_ch_q;
    cfg_t        rec_q;
    logic [7:0]  rec_ch_q;
    logic        rec_vld_q;
    logic        len_err_q;

    cfg_t              bank_q [CH_NUM];
    cfg_t              bank_d [CH_NUM];
    logic [CH_NUM-1:0] cfg_vld_q, cfg_vld_d;
    logic [3:0]        err_q, err_d;
    logic [CNT_W-1:0]  ok_q, ok_d;
    logic [CNT_W-1:0]  errc_q, errc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_data_q <= '0;
            in_vld_q  <= 1'b0;
            in_last_q <= 1'b0;
        end else begin
            in_data_q <= bus.rx_axis_udp_tdata;
            in_vld_q  <= bus.rx_axis_udp_tvalid;
            in_last_q <= bus.rx_axis_udp_tlast;
        end
    end

    // Frame FSM: staging collects words 0..2; the commit record is a separate copy so
    // the next frame can start filling staging while the previous one is validated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            stage_ch_q <= '0;
            rec_q      <= '0;
            rec_ch_q   <= '0;
            rec_vld_q  <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            rec_vld_q <= 1'b0;
            len_err_q <= 1'b0;
            if (in_vld_q) begin
                case (state_q)
                    IDLE: begin
                        if (in_data_q[23:16] == 8'(ID_SENT_PARAM)) begin
                            stage_ch_q <= in_data_q[15:8];
                            if (!in_last_q) state_q <= W1;
                        end else if (!in_last_q) begin
                            state_q <= DROP;
                        end
                    end
                    W1: begin
                        stage_q.ctick      <= in_data_q[31:24];
                        stage_q.ltick      <= in_data_q[23:16];
                        stage_q.pmode      <= in_data_q[9:8];
                        stage_q.plen[15:8] <= in_data_q[7:0];
                        len_err_q          <= in_last_q;
                        state_q            <= in_last_q ? IDLE : W2;
                    end
                    W2: begin
                        stage_q.plen[7:0] <= in_data_q[31:24];
                        stage_q.crc       <= in_data_q[16];
                        stage_q.status    <= in_data_q[11:8];
                        stage_q.dlen      <= in_data_q[2:0];
                        len_err_q         <= in_last_q;
                        state_q           <= in_last_q ? IDLE : W3;
                    end
                    W3: begin
                        rec_q      <= stage_q;
                        rec_q.data <= in_data_q[31:8];
                        rec_ch_q   <= stage_ch_q;
                        rec_vld_q  <= in_last_q;
                        state_q    <= in_last_q ? IDLE : EXTRA;
                    end
                    EXTRA: begin
                        if (in_last_q) begin
                            len_err_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                    DROP: if (in_last_q) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    logic chan_err, range_err, rec_ok, overrun;

    always_comb begin
        chan_err  = rec_vld_q && (32'(rec_ch_q) >= CH_NUM) && (rec_ch_q != BCAST_IDX);
        range_err = rec_vld_q && !chan_err && out_of_range(rec_q);
        rec_ok    = rec_vld_q && !chan_err && !range_err;
        overrun   = 1'b0;
        cfg_vld_d = cfg_vld_q & ~bus.cfg_rdy;
        for (int i = 0; i < CH_NUM; i++) begin
            bank_d[i] = bank_q[i];
            if (rec_ok && ((rec_ch_q == BCAST_IDX) || (rec_ch_q == 8'(i)))) begin
                bank_d[i]    = rec_q;
                cfg_vld_d[i] = 1'b1;
                // A pending config consumed this same cycle is not an overrun.
                if (cfg_vld_q[i] && !bus.cfg_rdy[i]) overrun = 1'b1;
            end
        end
        err_d  = (bus.err_clr ? 4'b0000 : err_q) | {overrun, range_err, chan_err, len_err_q};
        ok_d   = rec_ok ? sat_inc(ok_q) : ok_q;
        errc_d = (chan_err || range_err || len_err_q) ? sat_inc(errc_q) : errc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) bank_q[i] <= '0;
            cfg_vld_q <= '0;
            err_q     <= '0;
            ok_q      <= '0;
            errc_q    <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) bank_q[i] <= bank_d[i];
            cfg_vld_q <= cfg_vld_d;
            err_q     <= err_d;
            ok_q      <= ok_d;
            errc_q    <= errc_d;
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_out
        assign bus.sent_ctick_len[8*g +: 8]      = bank_q[g].ctick;
        assign bus.sent_ltick_len[8*g +: 8]      = bank_q[g].ltick;
        assign bus.sent_pause_mode[2*g +: 2]     = bank_q[g].pmode;
        assign bus.sent_pause_len[16*g +: 16]    = bank_q[g].plen;
        assign bus.sent_crc_mode[g]              = bank_q[g].crc;
        assign bus.sent_status_nibble[4*g +: 4]  = bank_q[g].status;
        assign bus.sent_data_len[3*g +: 3]       = bank_q[g].dlen;
        assign bus.sent_data_nibble[24*g +: 24]  = bank_q[g].data;
    end

    assign bus.cfg_vld     = cfg_vld_q;
    assign bus.err_flags   = err_q;
    assign bus.cfg_ok_cnt  = ok_q;
    assign bus.cfg_err_cnt = errc_q;
endmodule

// File: tb/tb_sent_config_bank.sv
// Directed bench for sent_config_bank: frames are encoded from field values, expected
// commits go through a scoreboard queue and are checked two edges after the last beat.
module tb_sent_config_bank;
    localparam int CH = 8;
    localparam int CW = 16;

    typedef struct {
        logic [CH-1:0] mask;
        logic [7:0]    ct;
        logic [7:0]    lt;
        logic [1:0]    pm;
        logic [15:0]   pl;
        logic          crc;
        logic [3:0]    st;
        logic [2:0]    dl;
        logic [23:0]   d;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] fw [$];
    bit          fl [$];
    exp_t        sb [$];

    sent_config_bank_if #(.CH_NUM(CH), .CNT_W(CW)) bus ();

    sent_config_bank #(
        .ID_SENT_PARAM(2), .CH_NUM(CH), .BCAST_IDX(8'hFF), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input logic [7:0] id, input logic [7:0] ch,
                             input logic [7:0] ct, input logic [7:0] lt,
                             input logic [1:0] pm, input logic [15:0] pl,
                             input logic crc, input logic [3:0] st,
                             input logic [2:0] dl, input logic [23:0] d,
                             input int nw, input bit push);
        logic [31:0] w [5];
        exp_t        e;
        w[0] = {8'h00, id, ch, 8'h00};
        w[1] = {ct, lt, 6'b0, pm, pl[15:8]};
        w[2] = {pl[7:0], 7'b0, crc, 4'b0, st, 5'b0, dl};
        w[3] = {d, 8'h00};
        w[4] = 32'hDEAD_BEEF;
        for (int k = 0; k < nw; k++) begin
            fw.push_back(w[k]);
            fl.push_back(k == nw - 1);
        end
        if (push) begin
            e.mask = (ch == 8'hFF) ? {CH{1'b1}} : (CH'(1) << ch);
            e.ct = ct; e.lt = lt; e.pm = pm; e.pl = pl;
            e.crc = crc; e.st = st; e.dl = dl; e.d = d;
            sb.push_back(e);
        end
    endtask

    task automatic send_frame();
        while (fw.size() > 0) begin
            bus.rx_axis_udp_tdata  = fw.pop_front();
            bus.rx_axis_udp_tlast  = fl.pop_front();
            bus.rx_axis_udp_tvalid = 1'b1;
            @(negedge clk);
        end
        bus.rx_axis_udp_tvalid = 1'b0;
        bus.rx_axis_udp_tlast  = 1'b0;
    endtask

    // Called at the negedge after the tlast beat was registered.
    task automatic check_commit(input logic [CH-1:0] vld_before);
        exp_t e;
        @(negedge clk);
        check("latency_e1", bus.cfg_vld, vld_before);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected pending commit");
        end else begin
            e = sb.pop_front();
            check("cfg_vld_mask", bus.cfg_vld & e.mask, e.mask);
            for (int c = 0; c < CH; c++) begin
                if (e.mask[c]) begin
                    check($sformatf("ctick[%0d]", c), bus.sent_ctick_len[8*c +: 8], e.ct);
                    check($sformatf("ltick[%0d]", c), bus.sent_ltick_len[8*c +: 8], e.lt);
                    check($sformatf("pmode[%0d]", c), bus.sent_pause_mode[2*c +: 2], e.pm);
                    check($sformatf("plen[%0d]", c), bus.sent_pause_len[16*c +: 16], e.pl);
                    check($sformatf("crc[%0d]", c), bus.sent_crc_mode[c], e.crc);
                    check($sformatf("status[%0d]", c), bus.sent_status_nibble[4*c +: 4], e.st);
                    check($sformatf("dlen[%0d]", c), bus.sent_data_len[3*c +: 3], e.dl);
                    check($sformatf("data[%0d]", c), bus.sent_data_nibble[24*c +: 24], e.d);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic bank_any();
        return |{bus.sent_ctick_len, bus.sent_ltick_len, bus.sent_pause_mode, bus.sent_pause_len,
                 bus.sent_crc_mode, bus.sent_status_nibble, bus.sent_data_len, bus.sent_data_nibble};
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.rx_axis_udp_tdata  = '0;
        bus.rx_axis_udp_tvalid = 1'b0;
        bus.rx_axis_udp_tlast  = 1'b0;
        bus.cfg_rdy            = '0;
        bus.err_clr            = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_cfg_vld", bus.cfg_vld, 0);
        check("rst_err_flags", bus.err_flags, 0);
        check("rst_ok_cnt", bus.cfg_ok_cnt, 0);
        check("rst_err_cnt", bus.cfg_err_cnt, 0);
        check("rst_bank", bank_any(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single valid frame to channel 3, then consume it.
        add_frame(8'd2, 8'd3, 8'd5, 8'd4, 2'd1, 16'd20, 1'b1, 4'hA, 3'd6, 24'h123456, 4, 1);
        send_frame();
        check_commit(8'h00);
        check("ch3_vld_exact", bus.cfg_vld, 8'h08);
        check("ch3_err_flags", bus.err_flags, 0);
        bus.cfg_rdy = 8'h08;
        @(negedge clk);
        bus.cfg_rdy = 8'h00;
        check("ch3_consumed", bus.cfg_vld, 8'h00);
        check("ch3_ok_cnt", bus.cfg_ok_cnt, 1);

        // Broadcast with boundary-valid values.
        add_frame(8'd2, 8'hFF, 8'd90, 8'd200, 2'd2, 16'd768, 1'b0, 4'h5, 3'd1, 24'hABCDEF, 4, 1);
        send_frame();
        check_commit(8'h00);
        check("bcast_vld", bus.cfg_vld, 8'hFF);
        check("bcast_ok_cnt", bus.cfg_ok_cnt, 2);
        bus.cfg_rdy = 8'hFF;
        @(negedge clk);
        bus.cfg_rdy = 8'h00;
        check("bcast_consumed", bus.cfg_vld, 8'h00);
        check("bcast_no_overrun", bus.err_flags, 0);

        // Five rejected frames on a clean bank.
        do_reset();
        add_frame(8'd2, 8'd1, 8'd91, 8'd4, 2'd0, 16'd0, 1'b0, 4'h0, 3'd3, 24'h000001, 4, 0);
        add_frame(8'd2, 8'd1, 8'd10, 8'd4, 2'd0, 16'd0, 1'b0, 4'h0, 3'd0, 24'h000002, 4, 0);
        add_frame(8'd2, 8'd9, 8'd10, 8'd4, 2'd0, 16'd0, 1'b0, 4'h0, 3'd3, 24'h000003, 4, 0);
        add_frame(8'd2, 8'd1, 8'd10, 8'd4, 2'd0, 16'd0, 1'b0, 4'h0, 3'd3, 24'h000004, 3, 0);
        add_frame(8'd2, 8'd1, 8'd10, 8'd4, 2'd0, 16'd0, 1'b0, 4'h0, 3'd3, 24'h000005, 5, 0);
        send_frame();
        repeat (3) @(negedge clk);
        check("fault_cfg_vld", bus.cfg_vld, 0);
        check("fault_bank", bank_any(), 0);
        check("fault_flags", bus.err_flags, 4'b0111);
        check("fault_err_cnt", bus.cfg_err_cnt, 5);
        check("fault_ok_cnt", bus.cfg_ok_cnt, 0);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("err_clr_flags", bus.err_flags, 0);
        check("err_clr_cnt_kept", bus.cfg_err_cnt, 5);

        // Back-to-back frames to channel 2 without a consumer: latest wins, overrun flagged.
        do_reset();
        add_frame(8'd2, 8'd2, 8'd3, 8'd4, 2'd0, 16'd0, 1'b0, 4'h0, 3'd3, 24'h111111, 4, 0);
        add_frame(8'd2, 8'd2, 8'd50, 8'd10, 2'd1, 16'd12, 1'b1, 4'hF, 3'd6, 24'h654321, 4, 1);
        send_frame();
        check_commit(8'h04);
        check("b2b_vld", bus.cfg_vld, 8'h04);
        check("b2b_overrun", bus.err_flags, 4'b1000);
        check("b2b_ok_cnt", bus.cfg_ok_cnt, 2);

        // Foreign ID frame directly followed by a valid frame to channel 5.
        add_frame(8'd1, 8'd5, 8'd1, 8'd1, 2'd3, 16'd1, 1'b1, 4'h1, 3'd0, 24'hFFFFFF, 4, 0);
        add_frame(8'd2, 8'd5, 8'd7, 8'd8, 2'd2, 16'd100, 1'b0, 4'h3, 3'd4, 24'h0FEDCB, 4, 1);
        send_frame();
        check_commit(8'h04);
        check("foreign_vld", bus.cfg_vld, 8'h24);
        check("foreign_ok_cnt", bus.cfg_ok_cnt, 3);
        check("foreign_err_cnt", bus.cfg_err_cnt, 0);

        // Reset in the middle of a frame, then a full frame after release.
        add_frame(8'd2, 8'd0, 8'd10, 8'd5, 2'd0, 16'd9999, 1'b1, 4'h1, 3'd2, 24'h00A5A5, 4, 0);
        bus.rx_axis_udp_tdata  = fw[0];
        bus.rx_axis_udp_tlast  = 1'b0;
        bus.rx_axis_udp_tvalid = 1'b1;
        @(negedge clk);
        bus.rx_axis_udp_tdata = fw[1];
        @(negedge clk);
        bus.rx_axis_udp_tvalid = 1'b0;
        fw.delete();
        fl.delete();
        rst_n = 1'b0;
        #1;
        check("midrst_cfg_vld", bus.cfg_vld, 0);
        check("midrst_ok_cnt", bus.cfg_ok_cnt, 0);
        check("midrst_flags", bus.err_flags, 0);
        check("midrst_bank", bank_any(), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        add_frame(8'd2, 8'd0, 8'd10, 8'd5, 2'd0, 16'd9999, 1'b1, 4'h1, 3'd2, 24'h00A5A5, 4, 1);
        send_frame();
        check_commit(8'h00);
        check("postrst_vld", bus.cfg_vld, 8'h01);
        check("postrst_ok_cnt", bus.cfg_ok_cnt, 1);
        check("postrst_err_cnt", bus.cfg_err_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
